// File: rtl/compare_arbiter.sv
// Round-robin share of one signed comparator between two requesters; result registered, 1-cycle latency.
// Grants only when the response slot is empty or draining; a stalled response holds and blocks all grants.
module compare_arbiter #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic [TAG_W-1:0] r0_tag,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   input  logic [TAG_W-1:0] r1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_gt,
   output logic             rsp_lt,
   output logic             rsp_eq,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic             gt;
      logic             lt;
      logic             eq;
   } rsp_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   rsp_t                    rsp_q;
   rsp_t                    rsp_d;
   logic                    rr_ptr;
   logic                    slot_free;
   logic                    grant0;
   logic                    grant1;
   logic                    hs;
   logic signed [WIDTH-1:0] op_a;
   logic signed [WIDTH-1:0] op_b;

   // Grants depend only on valids, flush and slot state, never on operands.
   // Reset also gates grants so no ready is seen while reset is held.
   always_comb begin
      slot_free = !rsp_valid || rsp_ready;
      grant0    = !reset && !flush && slot_free && r0_valid && (!r1_valid || !rr_ptr);
      grant1    = !reset && !flush && slot_free && r1_valid && (!r0_valid || rr_ptr);
   end

   assign r0_ready = grant0;
   assign r1_ready = grant1;
   assign hs       = grant0 || grant1;

   always_comb begin
      op_a      = grant1 ? r1_a : r0_a;
      op_b      = grant1 ? r1_b : r0_b;
      rsp_d     = '0;
      rsp_d.id  = grant1;
      rsp_d.tag = grant1 ? r1_tag : r0_tag;
      rsp_d.gt  = op_a > op_b;
      rsp_d.lt  = op_a < op_b;
      rsp_d.eq  = op_a == op_b;
   end

   // Flush wins over both a new grant and a draining consumer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
         rr_ptr    <= 1'b0;
      end else begin
         if (flush) begin
            rsp_valid <= 1'b0;
         end else if (hs) begin
            rsp_valid <= 1'b1;
            rsp_q     <= rsp_d;
            rr_ptr    <= grant0;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (grant0 && cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_ONE;
         if (grant1 && cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_ONE;
      end
   end

   assign rsp_id  = rsp_q.id;
   assign rsp_tag = rsp_q.tag;
   assign rsp_gt  = rsp_q.gt;
   assign rsp_lt  = rsp_q.lt;
   assign rsp_eq  = rsp_q.eq;

endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: table vectors plus hand sequences, results checked through a scoreboard queue.
module tb_compare_arbiter;

   localparam int WIDTH = 16;
   localparam int TAG_W = 4;
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic             gt;
      logic             lt;
      logic             eq;
   } exp_t;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
      logic             gt;
      logic             lt;
      logic             eq;
   } vec_t;

   logic             clk;
   logic             reset;
   logic             flush;
   logic             r0_valid, r0_ready, r1_valid, r1_ready;
   logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
   logic [TAG_W-1:0] r0_tag, r1_tag;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_gt, rsp_lt, rsp_eq;
   logic [CNT_W-1:0] cnt0, cnt1;

   int               checks = 0;
   int               errors = 0;
   exp_t             sbq[$];
   exp_t             exp0, exp1;
   logic             m_rv, m_rr;
   logic [CNT_W-1:0] m_c0, m_c1;

   compare_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
      .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .cnt0(cnt0), .cnt1(cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                       input logic gt, input logic lt, input logic eq);
      r0_a = a; r0_b = b; r0_tag = t;
      exp0 = '{id: 1'b0, tag: t, gt: gt, lt: lt, eq: eq};
   endtask

   task automatic set1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                       input logic gt, input logic lt, input logic eq);
      r1_a = a; r1_b = b; r1_tag = t;
      exp1 = '{id: 1'b1, tag: t, gt: gt, lt: lt, eq: eq};
   endtask

   task automatic model_clear();
      m_rv = 1'b0; m_rr = 1'b0; m_c0 = '0; m_c1 = '0;
      sbq.delete();
   endtask

   // Called right after inputs are driven at a falling edge; returns at the next falling edge.
   task automatic cycle(output logic got0, output logic got1);
      logic g0, g1, fr;
      exp_t e;
      #1;
      fr = !m_rv || rsp_ready;
      g0 = !flush && fr && r0_valid && (!r1_valid || !m_rr);
      g1 = !flush && fr && r1_valid && (!r0_valid || m_rr);
      got0 = r0_ready;
      got1 = r1_ready;
      chk("r0_ready", 32'(r0_ready), 32'(g0));
      chk("r1_ready", 32'(r1_ready), 32'(g1));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("cnt0", 32'(cnt0), 32'(m_c0));
      chk("cnt1", 32'(cnt1), 32'(m_c1));
      if (m_rv && flush) begin
         if (sbq.size() > 0) e = sbq.pop_front();
      end else if (m_rv && rsp_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            chk("rsp_gt", 32'(rsp_gt), 32'(e.gt));
            chk("rsp_lt", 32'(rsp_lt), 32'(e.lt));
            chk("rsp_eq", 32'(rsp_eq), 32'(e.eq));
         end
      end
      if (flush) begin
         m_rv = 1'b0;
      end else if (g0 || g1) begin
         sbq.push_back(g1 ? exp1 : exp0);
         m_rv = 1'b1;
         m_rr = g0;
         if (g0 && m_c0 != CMAX) m_c0 = m_c0 + 1'b1;
         if (g1 && m_c1 != CMAX) m_c1 = m_c1 + 1'b1;
      end else if (rsp_ready) begin
         m_rv = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_fields", 32'({rsp_id, rsp_tag, rsp_gt, rsp_lt, rsp_eq}), 32'd0);
      chk("reset_cnt", 32'({cnt0, cnt1}), 32'd0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle_all();
      r0_valid = 1'b0; r1_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
   endtask

   initial begin
      vec_t vt[8];
      logic g0, g1;
      int   k;
      vt[0] = '{16'h0003, 16'h0002, 4'd5, 1'b1, 1'b0, 1'b0};
      vt[1] = '{16'h8000, 16'h7FFF, 4'd1, 1'b0, 1'b1, 1'b0};
      vt[2] = '{16'hFFD8, 16'hFFD8, 4'd2, 1'b0, 1'b0, 1'b1};
      vt[3] = '{16'h0028, 16'h0028, 4'd3, 1'b0, 1'b0, 1'b1};
      vt[4] = '{16'h001E, 16'h0028, 4'd4, 1'b0, 1'b1, 1'b0};
      vt[5] = '{16'h7FFF, 16'h8000, 4'd6, 1'b1, 1'b0, 1'b0};
      vt[6] = '{16'hFFFF, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b0};
      vt[7] = '{16'h0000, 16'hFFFF, 4'd8, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      idle_all();
      set0('0, '0, '0, 1'b0, 1'b0, 1'b1);
      set1('0, '0, '0, 1'b0, 1'b0, 1'b1);
      model_clear();
      do_reset();

      // single request
      set0(16'd3, 16'd2, 4'd5, 1'b1, 1'b0, 1'b0);
      r0_valid = 1'b1;
      cycle(g0, g1);
      chk("single_grant", 32'(g0), 32'd1);
      r0_valid = 1'b0;
      chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("single_cnt0", 32'(cnt0), 32'd1);
      cycle(g0, g1);

      // table vectors back-to-back on r0
      for (int i = 0; i < 8; i++) begin
         set0(vt[i].a, vt[i].b, vt[i].tag, vt[i].gt, vt[i].lt, vt[i].eq);
         r0_valid = 1'b1;
         cycle(g0, g1);
         chk("vec_accept", 32'(g0), 32'd1);
      end
      r0_valid = 1'b0;
      cycle(g0, g1);
      cycle(g0, g1);

      // fairness
      do_reset();
      set0(-16'sd10, 16'sd10, 4'd1, 1'b0, 1'b1, 1'b0);
      set1(-16'sd20, -16'sd30, 4'd2, 1'b1, 1'b0, 1'b0);
      r0_valid = 1'b1; r1_valid = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k < 4; c++) begin
         cycle(g0, g1);
         if (g0 || g1) begin
            chk("fair_order", 32'(g1), 32'(k % 2));
            k++;
         end
      end
      chk("fair_accepts", 32'(k), 32'd4);
      r0_valid = 1'b0; r1_valid = 1'b0;
      cycle(g0, g1);
      chk("fair_cnt0", 32'(cnt0), 32'd2);
      chk("fair_cnt1", 32'(cnt1), 32'd2);
      cycle(g0, g1);

      // backpressure
      set0(16'd5, 16'd5, 4'd3, 1'b0, 1'b0, 1'b1);
      r0_valid = 1'b1;
      cycle(g0, g1);
      r0_valid = 1'b0;
      set1(16'd7, -16'sd7, 4'd9, 1'b1, 1'b0, 1'b0);
      r1_valid = 1'b1;
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle(g0, g1);
         chk("bp_no_grant", 32'({g0, g1}), 32'd0);
         chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_tag, rsp_gt, rsp_lt, rsp_eq}), 32'b1_0_0011_001);
      end
      rsp_ready = 1'b1;
      cycle(g0, g1);
      chk("bp_release_grant", 32'(g1), 32'd1);
      r1_valid = 1'b0;
      chk("bp_r1_rsp", 32'({rsp_valid, rsp_id, rsp_tag}), 32'b1_1_1001);
      cycle(g0, g1);
      cycle(g0, g1);

      // flush
      set1(16'd1, 16'd2, 4'd4, 1'b0, 1'b1, 1'b0);
      r1_valid = 1'b1;
      cycle(g0, g1);
      r1_valid = 1'b0;
      rsp_ready = 1'b0;
      flush = 1'b1;
      set0(16'd9, 16'd9, 4'd10, 1'b0, 1'b0, 1'b1);
      r0_valid = 1'b1;
      cycle(g0, g1);
      chk("flush_no_grant", 32'(g0), 32'd0);
      chk("flush_rsp_drop", 32'(rsp_valid), 32'd0);
      flush = 1'b0;
      rsp_ready = 1'b1;
      r1_valid = 1'b1;
      cycle(g0, g1);
      chk("flush_rr_kept", 32'({g0, g1}), 32'b10);
      idle_all();
      cycle(g0, g1);
      cycle(g0, g1);

      // saturation, then reset mid-response
      do_reset();
      set0(16'd1, 16'd1, 4'd6, 1'b0, 1'b0, 1'b1);
      r0_valid = 1'b1;
      for (int c = 0; c < 5; c++) cycle(g0, g1);
      r0_valid = 1'b0;
      rsp_ready = 1'b0;
      cycle(g0, g1);
      chk("sat_cnt0", 32'(cnt0), 32'd3);
      chk("sat_pending", 32'(rsp_valid), 32'd1);
      r0_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_cnt0", 32'(cnt0), 32'd0);
      chk("reset_no_ready", 32'({r0_ready, r1_ready}), 32'd0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      r1_valid = 1'b1;
      set1(16'd2, 16'd1, 4'd11, 1'b1, 1'b0, 1'b0);
      cycle(g0, g1);
      chk("post_reset_pref", 32'({g0, g1}), 32'b10);
      idle_all();
      cycle(g0, g1);
      cycle(g0, g1);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
